// File: rtl/admo_div_if.sv
// Request/response bundle between the execute stage and the iterative divider.
// The requester sits on the master side, the divider on the slave side.
interface admo_div_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start_i;
  logic [1:0]            op_i;
  logic [DATA_WIDTH-1:0] operand_a_i;
  logic [DATA_WIDTH-1:0] operand_b_i;
  logic                  kill_i;
  logic                  busy_o;
  logic                  valid_o;
  logic [DATA_WIDTH-1:0] result_o;

  modport master (
    output start_i, op_i, operand_a_i, operand_b_i, kill_i,
    input  busy_o, valid_o, result_o
  );

  modport slave (
    input  start_i, op_i, operand_a_i, operand_b_i, kill_i,
    output busy_o, valid_o, result_o
  );
endinterface

// File: rtl/admo_div.sv
// Restoring divider for RV32M DIV/DIVU/REM/REMU: one quotient bit per cycle on
// operand magnitudes, with the sign fix-up folded into the registered result.
module admo_div #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input logic       clk_i,
  input logic       rst_ni,
  admo_div_if.slave bus
);
  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  function automatic logic [W-1:0] neg_if(input logic en, input logic [W-1:0] v);
    return en ? (~v + W'(1)) : v;
  endfunction

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [W-1:0]         rem_q, rem_d;
  logic [W-1:0]         quo_q, quo_d;
  logic [W-1:0]         div_q, div_d;
  logic [W-1:0]         result_q, result_d;
  logic                 negq_q, negq_d;
  logic                 negr_q, negr_d;
  logic                 isrem_q, isrem_d;

  logic                 sign_a, sign_b;
  logic [W-1:0]         a_mag, b_mag;
  logic [W:0]           rem_sh, diff;
  logic [W-1:0]         rem_nx, quo_nx;

  // Signed ops work on magnitudes; 0x80000000 stays 2^31 read as unsigned.
  assign sign_a = ~bus.op_i[0] & bus.operand_a_i[W-1];
  assign sign_b = ~bus.op_i[0] & bus.operand_b_i[W-1];
  assign a_mag  = neg_if(sign_a, bus.operand_a_i);
  assign b_mag  = neg_if(sign_b, bus.operand_b_i);

  assign rem_sh = {rem_q, quo_q[W-1]};
  assign diff   = rem_sh - {1'b0, div_q};
  assign rem_nx = diff[W] ? rem_sh[W-1:0] : diff[W-1:0];
  assign quo_nx = {quo_q[W-2:0], ~diff[W]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    result_d = result_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    isrem_d  = isrem_q;
    if (bus.kill_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            if (bus.operand_b_i == '0) begin
              state_d  = S_DONE;
              result_d = bus.op_i[1] ? bus.operand_a_i : '1;
            end else begin
              state_d = S_CALC;
              cnt_d   = CNT_WIDTH'(W);
              rem_d   = '0;
              quo_d   = a_mag;
              div_d   = b_mag;
              negq_d  = sign_a ^ sign_b;
              negr_d  = sign_a;
              isrem_d = bus.op_i[1];
            end
          end
        end
        S_CALC: begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q - CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(1)) begin
            state_d  = S_DONE;
            result_d = isrem_q ? neg_if(negr_q, rem_nx) : neg_if(negq_q, quo_nx);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      result_q <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      isrem_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      result_q <= result_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      isrem_q  <= isrem_d;
    end
  end

  // A flush landing in DONE suppresses the pulse in that same cycle.
  assign bus.busy_o   = (state_q != S_IDLE);
  assign bus.valid_o  = (state_q == S_DONE) & ~bus.kill_i;
  assign bus.result_o = result_q;
endmodule

// File: doc/admo_div.md
Name: admo_div

Overview:
- Iterative restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Pairs with the ALU add/subtract path: each iteration is one trial subtraction, 1 quotient bit per cycle.
- Sits beside the combinational ALU in the execute stage. The pipeline stalls on busy_o and consumes the result on valid_o.

Parameters:
- DATA_WIDTH, 32, operand/result width; fixed to `DATA_WIDTH.
- CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  request; sampled only in IDLE.
- op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start_i.
- operand_a_i  input  DATA_WIDTH  dividend; sampled with start_i.
- operand_b_i  input  DATA_WIDTH  divisor; sampled with start_i.
- kill_i  input  1  pipeline flush; aborts any operation in flight.
- busy_o  output  1  high in CALC and DONE.
- valid_o  output  1  one-cycle pulse, result_o valid.
- result_o  output  DATA_WIDTH  quotient or remainder.

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE; busy_o=0, valid_o=0, result_o=0.
  - Counter, remainder and quotient registers cleared.
- States: IDLE, CALC, DONE.
- IDLE:
  - On start_i=1 and kill_i=0, latch op, signs and operand magnitudes.
  - Signed ops use the two's-complement absolute value; 0x80000000 maps to magnitude 2^31 (unsigned).
  - Load counter=DATA_WIDTH and go to CALC.
  - If the divisor is 0, go directly to DONE with the div-by-zero result.
- CALC, once per cycle:
  - Shift {rem,quo} left by 1.
  - Trial-subtract: diff = rem_shifted - divisor, in DATA_WIDTH+1 bits.
  - If diff non-negative: rem=diff, quo LSB=1. Otherwise restore rem, quo LSB=0.
  - Decrement counter; when the counter reaches 1 on the current cycle, go to DONE.
  - Exactly DATA_WIDTH CALC cycles.
- DONE (one cycle):
  - valid_o=1. result_o is registered on entry to DONE.
  - Next state IDLE; busy_o=0 from the next cycle.
- Latency:
  - start accepted at edge N → valid_o high in cycle N+33 (32 CALC + 1 DONE).
  - Div-by-zero: valid_o in cycle N+1.
- Sign fix-up, applied when entering DONE:
  - Quotient is negated if signed op and sign(a)≠sign(b).
  - Remainder is negated if signed op and sign(a)=1. The remainder takes the sign of the dividend.
- Special cases (RISC-V mandated):
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → operand_a unchanged.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: DIV → 0x80000000, REM → 0. This falls out of the magnitude path and needs no extra logic, but must hold.
- result_o holds its last value until the next DONE; it does not change in IDLE or CALC.
- start_i while busy_o=1 is ignored and not queued. The requester must hold start_i until it observes busy_o.
- kill_i=1 in any state:
  - Next state IDLE; valid_o forced 0 that cycle.
  - result_o unchanged; no result is produced.
  - kill_i has priority over start_i in IDLE.
- Back-to-back: start_i may be asserted in the same cycle valid_o is high. It is accepted in the following IDLE cycle, so the minimum spacing is 1 idle cycle.
- Reset mid-operation: immediate return to the reset values; no valid_o pulse.

Test Plan:
- DIVU, a=100, b=7 → valid_o exactly 33 cycles after start; result_o=14. REMU same operands → 2.
- DIV, a=-7 (0xFFFFFFF9), b=2 → 0xFFFFFFFD (-3). REM same → 0xFFFFFFFF (-1). REM a=7, b=-2 → 1.
- DIV and DIVU, b=0, a=0x12345678 → 0xFFFFFFFF after 1 cycle. REM/REMU, b=0 → 0x12345678.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM same → 0. DIVU 0xFFFFFFFF / 1 → 0xFFFFFFFF in 33 cycles.
- kill_i pulsed at CALC cycle 10 → busy_o low next cycle; no valid_o; result_o keeps the prior value. A new start (DIVU 9/3) completes with 3.
- Start during busy (second operand pair) → ignored, first result correct. rst_ni dropped mid-CALC → all outputs 0 asynchronously. Random 10k signed/unsigned pairs checked against a reference model.
